nh_lcd_bus_engine: RTL and testbench



---
 rtl/nh_lcd_pkg.sv | 22 ++
 rtl/nh_lcd_strobe_timer.sv | 48 ++++
 rtl/nh_lcd_bus_engine.sv | 227 ++++++++++++++++++++++
 tb/tb_nh_lcd_bus_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nh_lcd_pkg.sv
// Shared definitions for the 8080-style LCD bus engine: sequencer state encoding,
// bus-beat derivation and tearing-effect synchroniser depth.
package nh_lcd_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CMD_LOW   = 3'd1,
        CMD_HIGH  = 3'd2,
        TE_WAIT   = 3'd3,
        PIX_FETCH = 3'd4,
        PIX_LOW   = 3'd5,
        PIX_HIGH  = 3'd6
    } lcd_state_t;

    localparam int TE_SYNC_DEPTH = 2;

    // Number of bus beats needed to carry one pixel word.
    function automatic int calc_beats(input int pix_w, input int bus_w);
        return (pix_w + bus_w - 1) / bus_w;
    endfunction

endpackage

// File: rtl/nh_lcd_strobe_timer.sv
// Two-phase strobe timer: a low phase of low_cnt+1 cycles followed by a high phase
// of high_cnt+1 cycles; each count is sampled when its phase begins.
module nh_lcd_strobe_timer #(
    parameter int TIMER_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [TIMER_WIDTH-1:0] low_cnt,
    input  logic [TIMER_WIDTH-1:0] high_cnt,
    output logic                   phase_high,
    output logic                   phase_done
);

    logic                   running_q;
    logic [TIMER_WIDTH-1:0] cnt_q;

    assign phase_done = running_q && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            running_q  <= 1'b0;
            phase_high <= 1'b0;
        end else if (start) begin
            running_q  <= 1'b1;
            phase_high <= 1'b0;
        end else if (phase_done) begin
            if (!phase_high) begin
                phase_high <= 1'b1;
            end else begin
                running_q  <= 1'b0;
                phase_high <= 1'b0;
            end
        end
    end

    // A start pulse restarts immediately, so back-to-back beats need no gap cycle.
    always_ff @(posedge clk) begin
        if (start) begin
            cnt_q <= low_cnt;
        end else if (phase_done && !phase_high) begin
            cnt_q <= high_cnt;
        end else if (running_q && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/nh_lcd_bus_engine.sv
// 8080-style parallel LCD bus sequencer: single command/parameter beats, and
// TE-gated pixel frames with each pixel split MSB-first into bus beats.
module nh_lcd_bus_engine
    import nh_lcd_pkg::*;
#(
    parameter int BUS_WIDTH   = 8,
    parameter int PIXEL_WIDTH = 24,
    parameter int TIMER_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic [TIMER_WIDTH-1:0] i_strb_low,
    input  logic [TIMER_WIDTH-1:0] i_strb_high,
    input  logic                   i_cmd_stb,
    input  logic                   i_cmd_read,
    input  logic                   i_cmd_parameter,
    input  logic [BUS_WIDTH-1:0]   i_cmd_data,
    output logic [BUS_WIDTH-1:0]   o_cmd_data,
    output logic                   o_cmd_busy,
    output logic                   o_cmd_finished,
    input  logic                   i_start_frame,
    input  logic [31:0]            i_num_pixels,
    input  logic                   i_enable_tearing,
    input  logic                   i_tearing_effect,
    input  logic                   i_pix_valid,
    output logic                   o_pix_ready,
    input  logic [PIXEL_WIDTH-1:0] i_pix_data,
    output logic                   o_frame_busy,
    output logic                   o_frame_done,
    output logic                   o_register_data_sel,
    output logic                   o_write_n,
    output logic                   o_read_n,
    output logic                   o_read_en,
    output logic [BUS_WIDTH-1:0]   o_data,
    input  logic [BUS_WIDTH-1:0]   i_data
);

    localparam int BEATS = calc_beats(PIXEL_WIDTH, BUS_WIDTH);
    localparam int PAD_W = BEATS * BUS_WIDTH;
    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    lcd_state_t state_q, state_d;

    logic [TE_SYNC_DEPTH-1:0] te_sync_p0;
    logic                     te_sync_p1;
    logic                     te_rise;

    logic             timer_start, phase_high, phase_done, low_done, high_done;
    logic             accept_cmd, accept_frame, pix_take, beat_next, pix_end, frame_end;
    logic             capture_rd, stop_req, last_beat, last_pixel;
    logic             cmd_read_q, cmd_param_q, abort_q;
    logic             frame_busy_q, frame_done_q;
    logic [PAD_W-1:0] pix_q;
    logic [IDX_W-1:0] beat_idx_q;
    logic [31:0]      pix_cnt_q;

    // Beat idx of a zero-padded pixel, counted from the most significant end.
    function automatic logic [BUS_WIDTH-1:0] beat_slice(input logic [PAD_W-1:0] pad,
                                                       input logic [IDX_W-1:0] idx);
        return BUS_WIDTH'(pad >> ((BEATS - 1 - int'(idx)) * BUS_WIDTH));
    endfunction

    nh_lcd_strobe_timer #(
        .TIMER_WIDTH(TIMER_WIDTH)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .start     (timer_start),
        .low_cnt   (i_strb_low),
        .high_cnt  (i_strb_high),
        .phase_high(phase_high),
        .phase_done(phase_done)
    );

    assign low_done   = phase_done && !phase_high;
    assign high_done  = phase_done && phase_high;
    assign stop_req   = abort_q || !i_enable;
    assign last_beat  = (beat_idx_q == IDX_W'(BEATS - 1));
    assign last_pixel = (pix_cnt_q == 32'd1);
    assign capture_rd = (state_q == CMD_LOW) && cmd_read_q && low_done;

    // TE pin synchroniser stage, followed by rising-edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            te_sync_p0 <= '0;
            te_sync_p1 <= 1'b0;
        end else begin
            te_sync_p0 <= {te_sync_p0[TE_SYNC_DEPTH-2:0], i_tearing_effect};
            te_sync_p1 <= te_sync_p0[TE_SYNC_DEPTH-1];
        end
    end

    assign te_rise = te_sync_p0[TE_SYNC_DEPTH-1] && !te_sync_p1;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d             = state_q;
        timer_start         = 1'b0;
        accept_cmd          = 1'b0;
        accept_frame        = 1'b0;
        pix_take            = 1'b0;
        beat_next           = 1'b0;
        pix_end             = 1'b0;
        frame_end           = 1'b0;
        o_write_n           = 1'b1;
        o_read_n            = 1'b1;
        o_read_en           = 1'b0;
        o_register_data_sel = 1'b1;
        o_cmd_busy          = 1'b0;
        o_cmd_finished      = 1'b0;
        o_pix_ready         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_enable && i_cmd_stb) begin
                    accept_cmd  = 1'b1;
                    timer_start = 1'b1;
                    state_d     = CMD_LOW;
                end else if (i_enable && i_start_frame) begin
                    accept_frame = 1'b1;
                    if (i_num_pixels == '0) state_d = IDLE;
                    else if (i_enable_tearing) state_d = TE_WAIT;
                    else state_d = PIX_FETCH;
                end
            end
            CMD_LOW: begin
                o_cmd_busy          = 1'b1;
                o_register_data_sel = cmd_param_q;
                o_write_n           = cmd_read_q;
                o_read_n            = !cmd_read_q;
                o_read_en           = !cmd_read_q;
                if (low_done) state_d = CMD_HIGH;
            end
            CMD_HIGH: begin
                o_cmd_busy          = 1'b1;
                o_register_data_sel = cmd_param_q;
                o_read_en           = !cmd_read_q;
                if (high_done) begin
                    o_cmd_finished = !stop_req;
                    state_d        = IDLE;
                end
            end
            TE_WAIT: begin
                if (!i_enable) state_d = IDLE;
                else if (te_rise) state_d = PIX_FETCH;
            end
            PIX_FETCH: begin
                o_pix_ready = i_pix_valid && i_enable;
                if (!i_enable) begin
                    state_d = IDLE;
                end else if (i_pix_valid) begin
                    pix_take    = 1'b1;
                    timer_start = 1'b1;
                    state_d     = PIX_LOW;
                end
            end
            PIX_LOW: begin
                o_write_n = 1'b0;
                o_read_en = 1'b1;
                if (low_done) state_d = PIX_HIGH;
            end
            PIX_HIGH: begin
                o_read_en = 1'b1;
                // A disable is honoured only at a beat boundary so the bus hold time is kept.
                if (high_done) begin
                    if (stop_req) begin
                        state_d = IDLE;
                    end else if (!last_beat) begin
                        beat_next   = 1'b1;
                        timer_start = 1'b1;
                        state_d     = PIX_LOW;
                    end else begin
                        pix_end = 1'b1;
                        if (last_pixel) begin
                            frame_end = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            state_d = PIX_FETCH;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_data       <= '0;
            o_cmd_data   <= '0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            frame_busy_q <= accept_frame || (state_d inside {TE_WAIT, PIX_FETCH, PIX_LOW, PIX_HIGH});
            frame_done_q <= (accept_frame && i_num_pixels == '0) || frame_end;
            abort_q      <= (state_d != IDLE) && (abort_q || !i_enable);
            if (accept_cmd)     o_data <= i_cmd_data;
            else if (pix_take)  o_data <= beat_slice(PAD_W'(i_pix_data), '0);
            else if (beat_next) o_data <= beat_slice(pix_q, beat_idx_q + 1'b1);
            if (capture_rd)     o_cmd_data <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_cmd) begin
            cmd_read_q  <= i_cmd_read;
            cmd_param_q <= i_cmd_parameter;
        end
        if (accept_frame)  pix_cnt_q <= i_num_pixels;
        else if (pix_end)  pix_cnt_q <= pix_cnt_q - 32'd1;
        if (pix_take) begin
            pix_q      <= PAD_W'(i_pix_data);
            beat_idx_q <= '0;
        end else if (beat_next) begin
            beat_idx_q <= beat_idx_q + 1'b1;
        end
    end

    assign o_frame_busy = frame_busy_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_nh_lcd_bus_engine.sv
// Directed bench for nh_lcd_bus_engine (8-bit bus, 24-bit pixels): table-driven
// command beats plus hand-written frame, TE, stall, abort and reset sequences.
module tb_nh_lcd_bus_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic [3:0]  i_strb_low, i_strb_high;
    logic        i_cmd_stb, i_cmd_read, i_cmd_parameter;
    logic [7:0]  i_cmd_data;
    logic [7:0]  o_cmd_data;
    logic        o_cmd_busy, o_cmd_finished;
    logic        i_start_frame;
    logic [31:0] i_num_pixels;
    logic        i_enable_tearing, i_tearing_effect;
    logic        i_pix_valid, o_pix_ready;
    logic [23:0] i_pix_data;
    logic        o_frame_busy, o_frame_done;
    logic        o_register_data_sel, o_write_n, o_read_n, o_read_en;
    logic [7:0]  o_data, i_data;

    nh_lcd_bus_engine #(
        .BUS_WIDTH  (8),
        .PIXEL_WIDTH(24),
        .TIMER_WIDTH(4)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_enable           (i_enable),
        .i_strb_low         (i_strb_low),
        .i_strb_high        (i_strb_high),
        .i_cmd_stb          (i_cmd_stb),
        .i_cmd_read         (i_cmd_read),
        .i_cmd_parameter    (i_cmd_parameter),
        .i_cmd_data         (i_cmd_data),
        .o_cmd_data         (o_cmd_data),
        .o_cmd_busy         (o_cmd_busy),
        .o_cmd_finished     (o_cmd_finished),
        .i_start_frame      (i_start_frame),
        .i_num_pixels       (i_num_pixels),
        .i_enable_tearing   (i_enable_tearing),
        .i_tearing_effect   (i_tearing_effect),
        .i_pix_valid        (i_pix_valid),
        .o_pix_ready        (o_pix_ready),
        .i_pix_data         (i_pix_data),
        .o_frame_busy       (o_frame_busy),
        .o_frame_done       (o_frame_done),
        .o_register_data_sel(o_register_data_sel),
        .o_write_n          (o_write_n),
        .o_read_n           (o_read_n),
        .o_read_en          (o_read_en),
        .o_data             (o_data),
        .i_data             (i_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rd;
        logic       prm;
        logic [7:0] data;
        logic [3:0] lo;
        logic [3:0] hi;
        logic [7:0] bus_in;
        int         exp_lo;
        int         exp_hi;
        int         exp_fin;
        logic [7:0] exp_rdata;
    } cmd_vec_t;

    cmd_vec_t    cmd_tbl [5];
    logic [23:0] pix_tbl [8];
    logic [7:0]  exp_beats [9];

    int         n_vec = 0;
    int         n_err = 0;
    int         nbeats, low_cyc, act_cyc, done_cnt, done_cyc, first_fall, stall_low, dsel_bad;
    logic [7:0] beats [32];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " write_n"},   32'(o_write_n), 32'd1);
        chk({tag, " read_n"},    32'(o_read_n), 32'd1);
        chk({tag, " dc_sel"},    32'(o_register_data_sel), 32'd1);
        chk({tag, " read_en"},   32'(o_read_en), 32'd0);
        chk({tag, " data"},      32'(o_data), 32'd0);
        chk({tag, " cmd_data"},  32'(o_cmd_data), 32'd0);
        chk({tag, " cmd_busy"},  32'(o_cmd_busy), 32'd0);
        chk({tag, " cmd_fin"},   32'(o_cmd_finished), 32'd0);
        chk({tag, " frm_busy"},  32'(o_frame_busy), 32'd0);
        chk({tag, " frm_done"},  32'(o_frame_done), 32'd0);
        chk({tag, " pix_ready"}, 32'(o_pix_ready), 32'd0);
    endtask

    task automatic run_cmd(input int idx, input cmd_vec_t v);
        int lo_n, hi_n, fin_c, bad;
        lo_n = 0; hi_n = 0; fin_c = -1; bad = 0;
        i_strb_low = v.lo; i_strb_high = v.hi;
        i_cmd_read = v.rd; i_cmd_parameter = v.prm; i_cmd_data = v.data;
        i_data = v.bus_in; i_cmd_stb = 1'b1;
        for (int c = 1; c <= 80; c++) begin
            tick;
            i_cmd_stb = 1'b0;
            if (o_cmd_busy) begin
                if (!o_write_n || !o_read_n) lo_n++;
                else hi_n++;
                if (v.rd ? (!o_write_n || o_read_en) : (!o_read_n || !o_read_en || o_data !== v.data)) bad++;
                if (o_register_data_sel !== v.prm) bad++;
            end
            if (o_cmd_finished) begin
                fin_c = c;
                break;
            end
        end
        tick;
        chk($sformatf("cmd%0d low cycles", idx), 32'(lo_n), 32'(v.exp_lo));
        chk($sformatf("cmd%0d high cycles", idx), 32'(hi_n), 32'(v.exp_hi));
        chk($sformatf("cmd%0d finish cycle", idx), 32'(fin_c), 32'(v.exp_fin));
        chk($sformatf("cmd%0d bus/strobe faults", idx), 32'(bad), 32'd0);
        chk($sformatf("cmd%0d busy after", idx), 32'(o_cmd_busy), 32'd0);
        chk($sformatf("cmd%0d read data", idx), 32'(o_cmd_data), 32'(v.exp_rdata));
    endtask

    task automatic run_frame(input logic [31:0] npix, input logic te_en, input int te_cyc,
                             input int stall_s, input int stall_l, input int abort_c, input int ncyc);
        int   pidx;
        logic prev_wn;
        pidx = 0; prev_wn = 1'b1;
        nbeats = 0; low_cyc = 0; act_cyc = 0; done_cnt = 0; done_cyc = -1;
        first_fall = -1; stall_low = 0; dsel_bad = 0;
        i_num_pixels = npix; i_enable_tearing = te_en; i_start_frame = 1'b1;
        i_pix_valid = 1'b1; i_pix_data = pix_tbl[0];
        for (int c = 1; c <= ncyc; c++) begin
            tick;
            i_start_frame = 1'b0;
            if (prev_wn && !o_write_n) begin
                if (nbeats < 32) beats[nbeats] = o_data;
                nbeats++;
                if (first_fall < 0) first_fall = c;
            end
            if (!o_write_n) low_cyc++;
            if (!o_write_n && !o_register_data_sel) dsel_bad++;
            if (o_read_en) act_cyc++;
            if (o_frame_done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (c >= stall_s && c <= stall_s + stall_l && !o_write_n) stall_low++;
            prev_wn = o_write_n;
            i_tearing_effect = (te_cyc >= 0) && (c >= te_cyc);
            i_enable = !((abort_c >= 0) && (c >= abort_c));
            i_pix_valid = (pidx < int'(npix)) && !(c >= stall_s && c < stall_s + stall_l);
            i_pix_data = pix_tbl[pidx < 8 ? pidx : 7];
            #1;
            if (o_pix_ready) pidx++;
        end
        i_pix_valid = 1'b0;
    endtask

    initial begin
        int fb, fin, lo, pr;
        logic [7:0] d;

        cmd_tbl[0] = '{1'b0, 1'b0, 8'h2C, 4'd1,  4'd0,  8'h00, 2,  1,  3,  8'h00};
        cmd_tbl[1] = '{1'b1, 1'b1, 8'h00, 4'd2,  4'd1,  8'hA5, 3,  2,  5,  8'hA5};
        cmd_tbl[2] = '{1'b0, 1'b1, 8'h3A, 4'd0,  4'd0,  8'h00, 1,  1,  2,  8'hA5};
        cmd_tbl[3] = '{1'b0, 1'b0, 8'hFF, 4'd15, 4'd15, 8'h00, 16, 16, 32, 8'hA5};
        cmd_tbl[4] = '{1'b1, 1'b0, 8'h00, 4'd0,  4'd3,  8'h5A, 1,  4,  5,  8'h5A};

        rst = 1'b1; i_enable = 1'b1; i_strb_low = '0; i_strb_high = '0;
        i_cmd_stb = 1'b0; i_cmd_read = 1'b0; i_cmd_parameter = 1'b0; i_cmd_data = '0;
        i_start_frame = 1'b0; i_num_pixels = '0; i_enable_tearing = 1'b0;
        i_tearing_effect = 1'b0; i_pix_valid = 1'b1; i_pix_data = '0; i_data = '0;
        tick; tick; tick;
        check_reset_vals("por");
        rst = 1'b0; i_pix_valid = 1'b0;
        tick;

        for (int i = 0; i < 5; i++) run_cmd(i, cmd_tbl[i]);

        // Three-pixel frame, no TE, minimum timing
        pix_tbl[0] = 24'h112233; pix_tbl[1] = 24'h445566; pix_tbl[2] = 24'h778899;
        exp_beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        i_strb_low = 4'd0; i_strb_high = 4'd0;
        run_frame(32'd3, 1'b0, -1, 1000, 0, -1, 30);
        chk("frame beats", 32'(nbeats), 32'd9);
        for (int i = 0; i < 9; i++) chk($sformatf("frame beat%0d", i), 32'(beats[i]), 32'(exp_beats[i]));
        chk("frame strobe cycles", 32'(act_cyc), 32'd18);
        chk("frame low cycles", 32'(low_cyc), 32'd9);
        chk("frame dc_sel", 32'(dsel_bad), 32'd0);
        chk("frame done count", 32'(done_cnt), 32'd1);
        chk("frame done cycle", 32'(done_cyc), 32'd22);
        chk("frame busy after", 32'(o_frame_busy), 32'd0);

        // Same frame with pixel valid withdrawn for 5 cycles at a fetch point
        run_frame(32'd3, 1'b0, -1, 8, 5, -1, 35);
        chk("stall beats", 32'(nbeats), 32'd9);
        chk("stall beat3", 32'(beats[3]), 32'h44);
        chk("stall beat8", 32'(beats[8]), 32'h99);
        chk("stall strobes held", 32'(stall_low), 32'd0);
        chk("stall done cycle", 32'(done_cyc), 32'd27);

        // Zero-length frame
        run_frame(32'd0, 1'b0, -1, 1000, 0, -1, 4);
        chk("zero done count", 32'(done_cnt), 32'd1);
        chk("zero done cycle", 32'(done_cyc), 32'd1);
        chk("zero strobes", 32'(low_cyc), 32'd0);

        // TE-gated frame, pin rises 20 cycles after start
        pix_tbl[0] = 24'hABCDEF;
        run_frame(32'd1, 1'b1, 20, 1000, 0, -1, 40);
        chk("te gap >= 3", 32'(first_fall >= 23), 32'd1);
        chk("te first beat", 32'(beats[0]), 32'hAB);
        chk("te beats", 32'(nbeats), 32'd3);
        chk("te done count", 32'(done_cnt), 32'd1);
        i_tearing_effect = 1'b0; i_enable_tearing = 1'b0;
        tick; tick; tick;

        // Simultaneous command and frame start: the command wins
        i_strb_low = 4'd0; i_strb_high = 4'd0; i_cmd_read = 1'b0; i_cmd_parameter = 1'b0;
        i_cmd_data = 8'h55; i_num_pixels = 32'd2; i_cmd_stb = 1'b1; i_start_frame = 1'b1;
        i_pix_valid = 1'b1;
        fb = 0; fin = 0; lo = 0; pr = 0; d = '0;
        for (int c = 1; c <= 8; c++) begin
            tick;
            i_cmd_stb = 1'b0; i_start_frame = 1'b0;
            if (o_frame_busy) fb++;
            if (o_cmd_finished) fin++;
            if (o_pix_ready) pr++;
            if (!o_write_n) begin
                lo++;
                d = o_data;
            end
        end
        i_pix_valid = 1'b0;
        chk("simul frame busy", 32'(fb), 32'd0);
        chk("simul cmd finished", 32'(fin), 32'd1);
        chk("simul low cycles", 32'(lo), 32'd1);
        chk("simul cmd data", 32'(d), 32'h55);
        chk("simul pix ready", 32'(pr), 32'd0);

        // Abort: disable during the low phase of pixel 2 of 4
        pix_tbl[0] = 24'h010203; pix_tbl[1] = 24'h040506;
        pix_tbl[2] = 24'h070809; pix_tbl[3] = 24'h0A0B0C;
        i_strb_low = 4'd1; i_strb_high = 4'd1;
        run_frame(32'd4, 1'b0, -1, 1000, 0, 15, 25);
        chk("abort beats", 32'(nbeats), 32'd4);
        chk("abort last beat", 32'(beats[3]), 32'h04);
        chk("abort no done", 32'(done_cnt), 32'd0);
        chk("abort frame busy", 32'(o_frame_busy), 32'd0);
        chk("abort write_n idle", 32'(o_write_n), 32'd1);
        i_enable = 1'b1;
        tick;

        // Reset in the middle of a long command beat
        i_strb_low = 4'd5; i_strb_high = 4'd5; i_cmd_read = 1'b0; i_cmd_data = 8'h77;
        i_cmd_stb = 1'b1;
        tick;
        i_cmd_stb = 1'b0;
        tick; tick;
        chk("pre-rst strobe low", 32'(o_write_n), 32'd0);
        rst = 1'b1; i_pix_valid = 1'b1;
        tick;
        check_reset_vals("midrst");
        rst = 1'b0; i_pix_valid = 1'b0;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
